dip_input_ctrl: RTL and testbench

- Parametrised, memory-mapped switch/button input peripheral for the CPU SoC.
- Synchronises a WIDTH-bit raw input bus and debounces it with one shared counter.
- Records per-bit sticky change flags that the CPU clears by writing ones (W1C).
- Returns register contents on the shared 32-bit device read bus with one-cycle registered latency. Data is zero when the block is not selected, so the bus can be OR-combined.

---
 rtl/dip_input_ctrl_if.sv | 29 ++
 rtl/dip_input_ctrl.sv | 143 ++++++++++++++
 tb/tb_dip_input_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dip_input_ctrl_if.sv
// CPU device-bus bundle for the DIP/button input block.
// The master modport is the CPU side. The slave modport is the peripheral side.
// The irq wire is present only when DIP_IRQ_EN is defined.
interface dip_input_ctrl_if;
    logic        rd_ena;
    logic        wr_ena;
    logic [11:0] dv_addr;
    logic [31:0] data_fromcpu;
    logic [31:0] data_tocpu;
`ifdef DIP_IRQ_EN
    logic        irq;
`endif

    modport master (
        output rd_ena, wr_ena, dv_addr, data_fromcpu,
`ifdef DIP_IRQ_EN
        input  irq,
`endif
        input  data_tocpu
    );

    modport slave (
        input  rd_ena, wr_ena, dv_addr, data_fromcpu,
`ifdef DIP_IRQ_EN
        output irq,
`endif
        output data_tocpu
    );
endinterface

// File: rtl/dip_input_ctrl.sv
// Switch/button input peripheral: 3-flop sync, shared-counter debounce, W1C change flags, optional irq (DIP_IRQ_EN).
// Latency: read data registered, valid the cycle after rd_ena; input steps settle after DEBOUNCE_CYCLES+2 edges.
// Backpressure: none, the CPU strobes are accepted every cycle and unselected reads return zero for OR-combining.
module dip_input_ctrl #(
    parameter int unsigned WIDTH           = 24,
    parameter logic [11:0] BASEADDR        = 12'h070,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch,
    dip_input_ctrl_if.slave  bus
);
    localparam int unsigned      CNT_W       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]      ADDR_DATA   = BASEADDR;
    localparam logic [11:0]      ADDR_CHANGE = BASEADDR + 12'h4;
    localparam logic [11:0]      ADDR_RAW    = BASEADDR + 12'h8;
    localparam logic [11:0]      ADDR_MASK   = BASEADDR + 12'hC;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] change;
    logic [CNT_W-1:0] cnt;

    logic             sel_data;
    logic             sel_change;
    logic             sel_raw;
    logic             sel_mask;
    logic             deb_restart;
    logic             deb_done;
    logic [WIDTH-1:0] change_set;
    logic [WIDTH-1:0] change_clr;
    logic [WIDTH-1:0] change_nxt;
    logic [31:0]      rd_val;
    logic             unused_wdata;

`ifdef DIP_IRQ_EN
    logic [WIDTH-1:0] irq_mask;
`endif

    assign sel_data   = (bus.dv_addr == ADDR_DATA);
    assign sel_change = (bus.dv_addr == ADDR_CHANGE);
    assign sel_raw    = (bus.dv_addr == ADDR_RAW);
    assign sel_mask   = (bus.dv_addr == ADDR_MASK);

    // Write data above WIDTH has no destination.
    assign unused_wdata = ^bus.data_fromcpu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            samp  <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
            samp  <= sync2;
        end
    end

    // One counter covers the whole bus: any movement, or a return to the accepted value, restarts it.
    always_comb begin
        deb_restart = (sync2 != samp) || (samp == stable);
        deb_done    = !deb_restart && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            cnt    <= '0;
        end else if (deb_restart) begin
            cnt <= '0;
        end else if (deb_done) begin
            stable <= samp;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A flag raised on this edge survives a W1C aimed at the same bit.
    always_comb begin
        change_set = deb_done ? (stable ^ samp) : '0;
        change_clr = (bus.wr_ena && sel_change) ? bus.data_fromcpu[WIDTH-1:0] : '0;
        change_nxt = (change & ~change_clr) | change_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change <= '0;
        end else begin
            change <= change_nxt;
        end
    end

    always_comb begin
        rd_val = '0;
        if (bus.rd_ena) begin
            if (sel_data) begin
                rd_val[WIDTH-1:0] = stable;
            end else if (sel_change) begin
                rd_val[WIDTH-1:0] = change;
            end else if (sel_raw) begin
                rd_val[WIDTH-1:0] = sync2;
`ifdef DIP_IRQ_EN
            end else if (sel_mask) begin
                rd_val[WIDTH-1:0] = irq_mask;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_tocpu <= '0;
        end else begin
            bus.data_tocpu <= rd_val;
        end
    end

`ifdef DIP_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= '0;
        end else if (bus.wr_ena && sel_mask) begin
            irq_mask <= bus.data_fromcpu[WIDTH-1:0];
        end
    end

    // Registered from the current flags, so irq trails a flag set or clear by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.irq <= 1'b0;
        end else begin
            bus.irq <= |(change & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_dip_input_ctrl.sv
// Randomised bench for dip_input_ctrl against a sliding-window reference model.
// The reference model also covers irq when the bench is built with DIP_IRQ_EN.
module tb_dip_input_ctrl;
    localparam int          WIDTH = 24;
    localparam int          DEB   = 4;
    localparam logic [11:0] BASE  = 12'h070;
    localparam logic [11:0] A_DAT = BASE;
    localparam logic [11:0] A_CHG = BASE + 12'h4;
    localparam logic [11:0] A_RAW = BASE + 12'h8;
    localparam logic [11:0] A_MSK = BASE + 12'hC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] switch;

    dip_input_ctrl_if bus ();

    dip_input_ctrl #(
        .WIDTH          (WIDTH),
        .BASEADDR       (BASE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .switch(switch),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: captured switch history (oldest first) plus the register file.
    logic [WIDTH-1:0] cap[$];
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_change;
    logic [WIDTH-1:0] m_mask;
    logic [31:0]      m_rd;
    logic             m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // A value is accepted once the last DEB+1 samples seen by the second sync stage all agree on it.
    task automatic model_edge(input logic [WIDTH-1:0] sw, input logic rd, input logic wr,
                              input logic [11:0] addr, input logic [31:0] wdata);
        logic [WIDTH-1:0] s2;
        logic [WIDTH-1:0] nchg;
        logic [31:0]      regv;
        bit               agree;
        int               last;
        last  = cap.size() - 2;
        s2    = cap[last];
        agree = 1'b1;
        for (int j = 0; j <= DEB; j++) begin
            if (cap[last - j] != s2) agree = 1'b0;
        end
        regv = '0;
        if (addr == A_DAT) regv = ext(m_stable);
        else if (addr == A_CHG) regv = ext(m_change);
        else if (addr == A_RAW) regv = ext(s2);
`ifdef DIP_IRQ_EN
        else if (addr == A_MSK) regv = ext(m_mask);
`endif
        m_rd  = rd ? regv : 32'h0;
        m_irq = |(m_change & m_mask);
        nchg  = m_change;
        if (wr && addr == A_CHG) nchg = nchg & ~wdata[WIDTH-1:0];
        if (agree && s2 != m_stable) begin
            nchg     = nchg | (m_stable ^ s2);
            m_stable = s2;
        end
        m_change = nchg;
`ifdef DIP_IRQ_EN
        if (wr && addr == A_MSK) m_mask = wdata[WIDTH-1:0];
`endif
        cap.push_back(sw);
        void'(cap.pop_front());
    endtask

    // One clock: drive at the falling edge, clock it in, compare at the next falling edge.
    task automatic cyc(input logic [WIDTH-1:0] sw, input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [31:0] wdata);
        switch           = sw;
        bus.rd_ena       = rd;
        bus.wr_ena       = wr;
        bus.dv_addr      = addr;
        bus.data_fromcpu = wdata;
        model_edge(sw, rd, wr, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        chk("rdata", bus.data_tocpu, m_rd);
`ifdef DIP_IRQ_EN
        chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
`endif
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_stable = '0;
        m_change = '0;
        m_mask   = '0;
        m_rd     = '0;
        m_irq    = 1'b0;
        cap.delete();
        for (int i = 0; i < DEB + 3; i++) cap.push_back('0);
        @(negedge clk);
        chk("rst_dout", bus.data_tocpu, 32'h0);
`ifdef DIP_IRQ_EN
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cyc(input logic [WIDTH-1:0] sw);
        logic [11:0] addr;
        case ($urandom_range(0, 4))
            0: addr = A_DAT;
            1: addr = A_CHG;
            2: addr = A_RAW;
            3: addr = A_MSK;
            default: addr = 12'($urandom);
        endcase
        cyc(sw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), addr, $urandom);
    endtask

    logic [WIDTH-1:0] cur;

    initial begin
        switch           = '0;
        bus.rd_ena       = 1'b0;
        bus.wr_ena       = 1'b0;
        bus.dv_addr      = '0;
        bus.data_fromcpu = '0;
        do_reset();

        // Reads straight out of reset, with idle cycles in between.
        cyc('0, 1'b0, 1'b0, A_DAT, 32'h0);
        cyc('0, 1'b1, 1'b0, A_DAT, 32'h0);
        cyc('0, 1'b1, 1'b0, A_CHG, 32'h0);
        cyc('0, 1'b1, 1'b0, A_RAW, 32'h0);
        cyc('0, 1'b0, 1'b0, A_RAW, 32'h0);

        // Clean step, watching DATA every cycle.
        for (int i = 0; i < 10; i++) cyc(24'h00A5F0, 1'b1, 1'b0, A_DAT, 32'h0);
        chk("step_data", bus.data_tocpu, 32'h0000A5F0);
        cyc(24'h00A5F0, 1'b1, 1'b0, A_CHG, 32'h0);
        chk("step_chg", bus.data_tocpu, 32'h0000A5F0);
        cyc(24'h00A5F0, 1'b1, 1'b0, A_RAW, 32'h0);
        chk("step_raw", bus.data_tocpu, 32'h0000A5F0);

        // W1C with a concurrent read, then a write to read-only DATA.
        cyc(24'h00A5F0, 1'b1, 1'b1, A_CHG, 32'h000000F0);
        chk("w1c_rd_pre", bus.data_tocpu, 32'h0000A5F0);
        cyc(24'h00A5F0, 1'b1, 1'b0, A_CHG, 32'h0);
        chk("w1c_chg", bus.data_tocpu, 32'h0000A500);
        cyc(24'h00A5F0, 1'b0, 1'b1, A_DAT, 32'hFFFFFFFF);
        cyc(24'h00A5F0, 1'b1, 1'b0, A_DAT, 32'h0);
        chk("ro_data", bus.data_tocpu, 32'h0000A5F0);

        // Bit0 bounces every two cycles, then settles high.
        for (int i = 0; i < 10; i++)
            cyc(24'h00A5F0 | 24'((i / 2 + 1) % 2), 1'b1, 1'b0, A_DAT, 32'h0);
        for (int i = 0; i < 10; i++) cyc(24'h00A5F1, 1'b1, 1'b0, A_DAT, 32'h0);
        chk("bounce_data", bus.data_tocpu, 32'h0000A5F1);

        // Bit4 falls; a W1C of bit4 lands on the edge where stable moves.
        cyc(24'h00A5F1, 1'b0, 1'b1, A_CHG, 32'hFFFFFFFF);
        cyc(24'h00A5E1, 1'b0, 1'b0, A_DAT, 32'h0);
        for (int i = 1; i < 6; i++) cyc(24'h00A5E1, 1'b0, 1'b0, A_DAT, 32'h0);
        cyc(24'h00A5E1, 1'b0, 1'b1, A_CHG, 32'h00000010);
        cyc(24'h00A5E1, 1'b1, 1'b0, A_CHG, 32'h0);
        chk("collide_chg", bus.data_tocpu, 32'h00000010);

        // Random segments of varying hold length, with one reset mid-debounce.
        cur = 24'h00A5E1;
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            len = $urandom_range(1, 9);
            case ($urandom_range(0, 2))
                0: cur = cur ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                1: cur = WIDTH'($urandom);
                default: cur = cur ^ (WIDTH'($urandom) & WIDTH'($urandom));
            endcase
            for (int k = 0; k < len; k++) rand_cyc(cur);
            if (seg == 75) begin
                cyc(cur ^ 24'h000F00, 1'b0, 1'b0, A_DAT, 32'h0);
                cyc(cur ^ 24'h000F00, 1'b0, 1'b0, A_DAT, 32'h0);
                #2;
                do_reset();
            end
        end

`ifdef DIP_IRQ_EN
        do_reset();
        cyc('0, 1'b0, 1'b1, A_MSK, 32'h00000001);
        for (int i = 0; i < 10; i++) cyc(24'h000001, 1'b1, 1'b0, A_CHG, 32'h0);
        chk("irq_set", {31'b0, bus.irq}, 32'h1);
        cyc(24'h000001, 1'b0, 1'b1, A_CHG, 32'h00000001);
        cyc(24'h000001, 1'b0, 1'b0, A_CHG, 32'h0);
        chk("irq_clr", {31'b0, bus.irq}, 32'h0);
        for (int i = 0; i < 10; i++) cyc(24'h000003, 1'b1, 1'b0, A_CHG, 32'h0);
        chk("irq_masked", {31'b0, bus.irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
